// File: rtl/periph_io_arbiter.sv
// periph_io_arbiter: round-robin merge of NUM_REQ peripheral requesters onto
// the core's single inbound channel, plus a registered demux of the core's
// outbound channel to per-peripheral destination strobes.
// Optional build macro PIO_ARB_TIMEOUT_EN: abandons an offer the core has not
// acknowledged within TIMEOUT_CYCLES cycles and pulses timeout_pulse.
module periph_io_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MSG_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*MSG_WIDTH-1:0]  req_msg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [MSG_WIDTH-1:0]          from_peripheral,
  output logic [DATA_WIDTH-1:0]         from_peripheral_data,
  output logic                          from_peripheral_valid,
  input  logic                          core_ack,
  input  logic [MSG_WIDTH-1:0]          to_peripheral,
  input  logic [DATA_WIDTH-1:0]         to_peripheral_data,
  input  logic                          to_peripheral_valid,
  output logic [NUM_REQ-1:0]            dest_valid,
  output logic [DATA_WIDTH-1:0]         dest_data,
  output logic [7:0]                    drop_count,
  output logic                          timeout_pulse
);

  localparam int          PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_gnt;
  logic [MSG_WIDTH-1:0]  r_msg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_rr_next;
  logic [MSG_WIDTH-1:0]  w_msg_sel;
  logic [DATA_WIDTH-1:0] w_data_sel;
  logic [NUM_REQ-1:0]    w_ready;

  logic [NUM_REQ-1:0]    r_dest_valid;
  logic [DATA_WIDTH-1:0] r_dest_data;
  logic [7:0]            r_drop;
  logic [NUM_REQ-1:0]    w_dest_hit;
  logic                  w_drop;

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_tmo;
`endif

  // Round-robin winner: first valid requester scanning upward from r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((k + 32'(r_rr_ptr)) % NREQ_U);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  // Select the winner's message and payload, and the pointer after the current grant.
  always_comb begin
    w_msg_sel  = '0;
    w_data_sel = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (PTR_W'(i) == w_win) begin
        w_msg_sel  = req_msg[i*MSG_WIDTH +: MSG_WIDTH];
        w_data_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_rr_next = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
  end

  // Accept strobe: only the winner, only in IDLE; forced low while reset is held.
  always_comb begin
    w_ready = '0;
    if (reset && (r_state == S_IDLE) && w_found) begin
      w_ready[w_win] = 1'b1;
    end
  end

  // Inbound FSM: capture the winner's word, hold it until ack (or timeout).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_msg    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
`ifdef PIO_ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_win;
            r_msg   <= w_msg_sel;
            r_data  <= w_data_sel;
            r_valid <= 1'b1;
            r_state <= S_OFFER;
`ifdef PIO_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_OFFER: begin
          if (core_ack) begin
            r_valid  <= 1'b0;
            r_rr_ptr <= w_rr_next;
            r_state  <= S_IDLE;
`ifdef PIO_ARB_TIMEOUT_EN
          end else if (r_cnt == CNT_LAST) begin
            r_valid  <= 1'b0;
            r_msg    <= '0;
            r_data   <= '0;
            r_rr_ptr <= w_rr_next;
            r_tmo    <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outbound destination decode; an out-of-range index matches nothing.
  always_comb begin
    w_dest_hit = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      w_dest_hit[i] = to_peripheral_valid && (to_peripheral == MSG_WIDTH'(i));
    end
    w_drop = to_peripheral_valid && !(|w_dest_hit);
  end

  // Outbound register stage: one-cycle strobe, held payload, saturating drop count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dest_valid <= '0;
      r_dest_data  <= '0;
      r_drop       <= '0;
    end else begin
      r_dest_valid <= w_dest_hit;
      if (|w_dest_hit) begin
        r_dest_data <= to_peripheral_data;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign req_ready             = w_ready;
  assign from_peripheral       = r_msg;
  assign from_peripheral_data  = r_data;
  assign from_peripheral_valid = r_valid;
  assign dest_valid            = r_dest_valid;
  assign dest_data             = r_dest_data;
  assign drop_count            = r_drop;
`ifdef PIO_ARB_TIMEOUT_EN
  assign timeout_pulse         = r_tmo;
`else
  assign timeout_pulse         = 1'b0;
`endif

endmodule
